histogram_engine: RTL and testbench
===================================

Name: histogram_engine

Overview:
- Parametrised single-clock pixel histogram for the camera pipeline. Successor to the fixed 1024-bin/24-bit histogram.
- Bins incoming pixels during a framed image window using a hazard-safe read-modify-write pipeline.
- After the frame ends, streams every bin out over a valid/ready interface, clearing each bin as it is read, so the next frame starts from zero.
- Sits after the pixel unpacker; its readout feeds the U3V telemetry packetiser.

Parameters:
- PIXEL_WIDTH, 10, pixel data width in bits.
- BIN_BITS, 10, log2 of bin count. NUM_BINS = 2^BIN_BITS. Bin index = pixel[PIXEL_WIDTH-1 -: BIN_BITS]. Legal range 1..PIXEL_WIDTH.
- COUNT_WIDTH, 24, width of each bin counter and of the total counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse that opens an accumulation window.
- frame_end  in  1  one-cycle pulse that closes the window.
- pixel  in  PIXEL_WIDTH  pixel value.
- pixel_valid  in  1  qualifies pixel.
- busy  out  1  high in any state other than IDLE.
- histo_done  out  1  one-cycle pulse after the last bin is accepted.
- overrun  out  1  sticky error flag, cleared only by reset.
- out_valid  out  1  readout beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_bin  out  BIN_BITS  bin index of the current beat.
- out_count  out  COUNT_WIDTH  bin count of the current beat.
- out_last  out  1  marks the beat with out_bin = NUM_BINS-1.
- total_count  out  COUNT_WIDTH  pixels counted in the last frame. Valid from entry to READOUT until the next frame_start.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Enters CLEAR.
  - Reset values: busy=1, histo_done=0, overrun=0, out_valid=0, out_bin=0, out_count=0, out_last=0, total_count=0.
  - Reset asserted mid-frame or mid-readout aborts the operation and restarts CLEAR; no partial readout resumes.
- State CLEAR:
  - Writes zero to bins 0..NUM_BINS-1, one per cycle (NUM_BINS cycles), then goes to IDLE.
  - All inputs ignored. frame_start seen here sets overrun.
- State IDLE:
  - frame_start=1 resets total_count to 0 and moves to ACCUM on the next cycle.
  - pixel_valid and frame_end are ignored.
- State ACCUM:
  - Each cycle with pixel_valid=1 increments the selected bin and total_count.
  - Throughput: 1 pixel per clock, sustained indefinitely.
  - Memory is synchronous 1-cycle-read RAM, accessed as a 2-stage read-modify-write.
  - Back-to-back or one-apart pixels hitting the same bin must be counted exactly: in-flight results are forwarded, never lost.
  - Counters saturate at 2^COUNT_WIDTH-1; no wrap. total_count saturates the same way.
  - frame_end=1 together with pixel_valid=1: that pixel is counted.
  - frame_end moves to DRAIN.
  - frame_start while in ACCUM sets overrun and is otherwise ignored.
- State DRAIN:
  - Fixed 2 cycles for the pipeline to retire.
  - Pixels are ignored.
  - Then moves to READOUT.
- State READOUT:
  - Presents bins 0..NUM_BINS-1 in order.
  - First out_valid no more than 2 cycles after entry.
  - While out_valid=1 and out_ready=0, out_bin, out_count and out_last hold stable.
  - A beat transfers on out_valid and out_ready both high. That bin is written to zero (clear-on-read).
  - Full rate: one beat per clock when out_ready is held high.
  - After the out_last transfer: out_valid=0 next cycle, histo_done=1 for exactly one cycle, state goes to IDLE. Memory is all zero.
  - pixel_valid ignored.
  - frame_start sets overrun and is ignored; the frame is lost, not queued.
- Simultaneous frame_start and frame_end in IDLE: frame_start wins, frame_end is ignored.
- busy equals (state != IDLE), registered.

Test Plan (PIXEL_WIDTH=10, BIN_BITS=4, COUNT_WIDTH=8 unless noted):
- Reset, then wait 16 cycles → busy falls on cycle 17. Read out an empty frame: 16 beats, all out_count=0; out_last only on out_bin=15; histo_done pulses once; total_count=0.
- Frame of pixels 0x000, 0x040, 0x040, 0x3FF, all back-to-back → bin0=1, bin1=2, bin15=1, others 0; total_count=4.
- Frame of 300 consecutive pixel=0x080 → bin2=255 (saturated), total_count=255. Second frame with one pixel 0x080 → bin2=1, proving clear-on-read.
- Readout with out_ready toggling 1,0,0,1 repeatedly → beats never dropped or duplicated, outputs stable while stalled, 16 transfers total.
- frame_start during READOUT → overrun=1 and stays 1; readout completes unaffected. Only rst=0 clears overrun.
- rst=0 at beat 5 of readout → outputs take their reset values; after CLEAR, an empty frame reads back all zeros.

Source files
------------

// File: rtl/histogram_engine.sv
// Pixel histogram: bins pixels within a frame using a forwarded read-modify-write pipeline,
// then streams every bin out over valid/ready, clearing each bin as it is read.
module histogram_engine #(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned BIN_BITS    = 10,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic [PIXEL_WIDTH-1:0] pixel,
    input  logic                   pixel_valid,
    output logic                   busy,
    output logic                   histo_done,
    output logic                   overrun,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIN_BITS-1:0]    out_bin,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] total_count
);

    localparam int unsigned NUM_BINS = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LastBin = '1;
    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

    typedef enum logic [2:0] {StClear, StIdle, StAccum, StDrain, StReadout} state_e;

    state_e                 state_q, state_d;
    logic [BIN_BITS-1:0]    clr_ptr_q;
    logic                   drain_q;
    logic                   s1_valid_q;
    logic [BIN_BITS-1:0]    s1_bin_q;
    logic                   wr_valid_q;
    logic [BIN_BITS-1:0]    wr_bin_q;
    logic [COUNT_WIDTH-1:0] wr_data_q;
    logic [COUNT_WIDTH-1:0] rd_data_q;
    logic                   out_valid_q;
    logic [BIN_BITS-1:0]    out_bin_q;
    logic                   histo_done_q;
    logic                   overrun_q;
    logic                   busy_q;
    logic [COUNT_WIDTH-1:0] total_q;

    logic [COUNT_WIDTH-1:0] mem [NUM_BINS];

    logic [BIN_BITS-1:0]    pix_bin;
    logic [BIN_BITS-1:0]    rd_addr;
    logic                   mem_we;
    logic [BIN_BITS-1:0]    mem_waddr;
    logic [COUNT_WIDTH-1:0] mem_wdata;
    logic [COUNT_WIDTH-1:0] fwd;
    logic [COUNT_WIDTH-1:0] s1_new;
    logic                   fire;

    assign pix_bin = pixel[PIXEL_WIDTH-1 -: BIN_BITS];
    assign fire    = (state_q == StReadout) && out_valid_q && out_ready;

    // The RAM read issued one cycle ago misses only the write retired on that same edge.
    assign fwd    = (wr_valid_q && (wr_bin_q == s1_bin_q)) ? wr_data_q : rd_data_q;
    assign s1_new = (fwd == CountMax) ? fwd : fwd + COUNT_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        rd_addr   = out_bin_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                if (clr_ptr_q == LastBin) state_d = StIdle;
            end
            StIdle: begin
                if (frame_start) state_d = StAccum;
            end
            StAccum: begin
                rd_addr = pix_bin;
                if (frame_end) state_d = StDrain;
            end
            StDrain: begin
                if (drain_q) state_d = StReadout;
            end
            StReadout: begin
                // Look ahead on a transfer so the next bin is ready the following cycle.
                rd_addr = fire ? out_bin_q + BIN_BITS'(1) : out_bin_q;
                if (fire && (out_bin_q == LastBin)) state_d = StIdle;
            end
            default: state_d = StClear;
        endcase
        if (s1_valid_q) begin
            mem_we    = 1'b1;
            mem_waddr = s1_bin_q;
            mem_wdata = s1_new;
        end
        if (fire) begin
            mem_we    = 1'b1;
            mem_waddr = out_bin_q;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StClear;
            busy_q       <= 1'b1;
            clr_ptr_q    <= '0;
            drain_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_bin_q     <= '0;
            wr_valid_q   <= 1'b0;
            wr_bin_q     <= '0;
            wr_data_q    <= '0;
            out_valid_q  <= 1'b0;
            out_bin_q    <= '0;
            histo_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            total_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != StIdle);
            clr_ptr_q  <= (state_q == StClear) ? clr_ptr_q + BIN_BITS'(1) : '0;
            drain_q    <= (state_q == StDrain) ? ~drain_q : 1'b0;
            s1_valid_q <= (state_q == StAccum) && pixel_valid;
            s1_bin_q   <= pix_bin;
            wr_valid_q <= s1_valid_q;
            wr_bin_q   <= s1_bin_q;
            wr_data_q  <= s1_new;

            if ((state_q == StIdle) && frame_start) begin
                total_q <= '0;
            end else if ((state_q == StAccum) && pixel_valid && (total_q != CountMax)) begin
                total_q <= total_q + COUNT_WIDTH'(1);
            end

            if (frame_start && (state_q != StIdle)) overrun_q <= 1'b1;
            histo_done_q <= fire && (out_bin_q == LastBin);

            if (state_q == StReadout) begin
                if (fire) begin
                    out_bin_q <= out_bin_q + BIN_BITS'(1);
                    if (out_bin_q == LastBin) out_valid_q <= 1'b0;
                end else if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                end
            end else begin
                out_valid_q <= 1'b0;
                out_bin_q   <= '0;
            end
        end
    end

    assign busy        = busy_q;
    assign histo_done  = histo_done_q;
    assign overrun     = overrun_q;
    assign out_valid   = out_valid_q;
    assign out_bin     = out_bin_q;
    assign out_count   = out_valid_q ? rd_data_q : '0;
    assign out_last    = out_valid_q && (out_bin_q == LastBin);
    assign total_count = total_q;

endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: frames are driven from the main process, expected readout beats
// are queued by a reference histogram and checked by an independent output monitor.
module tb_histogram_engine;

    localparam int unsigned PW = 10;
    localparam int unsigned BB = 4;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [BB-1:0] bin;
        logic [CW-1:0] cnt;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          frame_end;
    logic [PW-1:0] pixel;
    logic          pixel_valid;
    logic          busy;
    logic          histo_done;
    logic          overrun;
    logic          out_valid;
    logic          out_ready;
    logic [BB-1:0] out_bin;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic [CW-1:0] total_count;

    histogram_engine #(
        .PIXEL_WIDTH(PW),
        .BIN_BITS   (BB),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .busy       (busy),
        .histo_done (histo_done),
        .overrun    (overrun),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_count  (out_count),
        .out_last   (out_last),
        .total_count(total_count)
    );

    always #5 clk = ~clk;

    int      n_tests = 0;
    int      n_fail  = 0;
    int      n_xfer  = 0;
    int      n_done  = 0;
    beat_t   exp_q[$];
    logic [PW-1:0] px_q[$];
    int      exp_bin[16];
    int      exp_total;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    logic  stall_q = 1'b0;
    logic  last_q  = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        if (!rst) begin
            stall_q = 1'b0;
            last_q  = 1'b0;
        end else begin
            if (histo_done) n_done++;
            if (last_q) check("valid_after_last", int'(out_valid), 0);
            if (stall_q) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_bin", int'(out_bin), int'(held.bin));
                check("stall_count", int'(out_count), int'(held.cnt));
                check("stall_last", int'(out_last), int'(held.last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", int'(out_bin), -1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_bin", int'(out_bin), int'(e.bin));
                    check("beat_count", int'(out_count), int'(e.cnt));
                    check("beat_last", int'(out_last), int'(e.last));
                end
                n_xfer++;
            end
            last_q  = out_valid && out_ready && out_last;
            stall_q = out_valid && !out_ready;
            held    = '{bin: out_bin, cnt: out_count, last: out_last};
        end
    end

    task automatic send_frame(input bit end_with_last);
        exp_total   = 0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        foreach (px_q[i]) begin
            int b;
            pixel       = px_q[i];
            pixel_valid = 1'b1;
            frame_end   = end_with_last && (i == px_q.size() - 1);
            b = int'(px_q[i][PW-1 -: BB]);
            if (exp_bin[b] != 255) exp_bin[b]++;
            if (exp_total != 255) exp_total++;
            tick;
        end
        pixel_valid = 1'b0;
        if (!(end_with_last && px_q.size() > 0)) begin
            frame_end = 1'b1;
            tick;
        end
        frame_end = 1'b0;
        for (int b = 0; b < 16; b++) begin
            exp_q.push_back('{bin: BB'(b), cnt: CW'(exp_bin[b]), last: (b == 15)});
            exp_bin[b] = 0;
        end
    endtask

    task automatic readout(input bit toggle, input bit fs_mid);
        int db;
        int xb;
        db = n_done;
        xb = n_xfer;
        for (int i = 0; i < 400 && n_done == db; i++) begin
            out_ready   = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            frame_start = fs_mid && (i == 8);
            tick;
        end
        frame_start = 1'b0;
        out_ready   = 1'b0;
        tick;
        tick;
        check("done_pulses", n_done - db, 1);
        check("transfers", n_xfer - xb, 16);
        check("queue_empty", exp_q.size(), 0);
        check("busy_after_readout", int'(busy), 0);
    endtask

    task automatic check_reset_values;
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(histo_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bin", int'(out_bin), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_total", int'(total_count), 0);
    endtask

    initial begin
        int xb;
        rst         = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pixel       = '0;
        pixel_valid = 1'b0;
        out_ready   = 1'b0;
        for (int b = 0; b < 16; b++) exp_bin[b] = 0;
        repeat (3) tick;
        check_reset_values();
        rst = 1'b1;
        repeat (15) tick;
        check("busy_in_clear", int'(busy), 1);
        tick;
        check("busy_after_clear", int'(busy), 0);

        // Empty frame
        px_q.delete();
        send_frame(1'b0);
        readout(1'b0, 1'b0);
        check("total_empty", int'(total_count), 0);

        // Back-to-back same bin, frame_end with the last pixel
        px_q = '{10'h000, 10'h040, 10'h040, 10'h3FF};
        send_frame(1'b1);
        readout(1'b0, 1'b0);
        check("total_four", int'(total_count), 4);

        // Alternating bins, one-apart hazards
        px_q = '{10'h040, 10'h080, 10'h040, 10'h080, 10'h040};
        send_frame(1'b0);
        readout(1'b1, 1'b0);
        check("total_alt", int'(total_count), 5);

        // Saturation, then clear-on-read
        px_q.delete();
        for (int i = 0; i < 300; i++) px_q.push_back(10'h080);
        send_frame(1'b0);
        readout(1'b0, 1'b0);
        check("total_sat", int'(total_count), 255);
        px_q = '{10'h080};
        send_frame(1'b0);
        readout(1'b1, 1'b0);
        check("total_one", int'(total_count), 1);

        // frame_start during readout
        check("overrun_before", int'(overrun), 0);
        px_q = '{10'h100};
        send_frame(1'b0);
        readout(1'b1, 1'b1);
        check("overrun_set", int'(overrun), 1);
        check("total_overrun_frame", int'(total_count), 1);

        // Reset in the middle of readout
        px_q = '{10'h3C0, 10'h3C0, 10'h3C0, 10'h200};
        send_frame(1'b0);
        check("overrun_sticky", int'(overrun), 1);
        xb = n_xfer;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (n_xfer - xb >= 5) break;
        end
        check("abort_point", n_xfer - xb, 5);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();
        tick;
        out_ready = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        repeat (16) tick;
        check("busy_after_reclear", int'(busy), 0);
        px_q.delete();
        send_frame(1'b0);
        readout(1'b0, 1'b0);
        check("total_after_abort", int'(total_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
